// File: rtl/fir_pkg.sv
// Shared defaults and sample types for the fir_filter output chain.
package fir_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int OUT_W_DEF      = 16;
  localparam int FRAC_SHIFT_DEF = 15;
  localparam int DECIM_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int DROP_CNT_W     = 16;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic signed [OUT_W_DEF-1:0]  out_sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered first-word fall-through head.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_nxt  = rd_ptr + 1'b1;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head follows the next stored word, or the incoming one when nothing else is queued.
      if (pop_ok && (count > CW'(1))) begin
        head <= mem[rd_nxt];
      end else if (push_ok && (empty || pop_ok)) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Keeps every DECIM-th fir_filter sample, rounds/requantizes it and buffers it for a valid/ready consumer.
// FIR_DECIM_SAT_EN selects clipping with sat_flag; otherwise the requantized value wraps.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     x_in,
  input  logic                  in_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat_flag,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  // Half an output LSB; collapses to zero when there is no shift.
  localparam logic [DATA_W:0] RND = ({{DATA_W{1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;

  logic [PH_W-1:0]          ph;
  logic                     keep;
  logic signed [DATA_W:0]   ext;
  logic signed [DATA_W:0]   rnd_sum;
  logic signed [DATA_W:0]   shifted;
  logic [OUT_W-1:0]         q_next;
  logic                     clip;
  logic                     q_valid;
  logic [OUT_W-1:0]         q_data;
  logic                     q_sat;
  logic                     pop;
  logic                     push;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     unused_hi;

  assign keep    = in_valid && (ph == '0);
  assign ext     = $signed({x_in[DATA_W-1], x_in});
  assign rnd_sum = ext + $signed(RND);
  assign shifted = rnd_sum >>> FRAC_SHIFT;
  assign unused_hi = ^shifted[DATA_W:OUT_W];

`ifdef FIR_DECIM_SAT_EN
  localparam logic signed [DATA_W:0] ONE  = 1;
  localparam logic signed [DATA_W:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [DATA_W:0] MINV = -(ONE <<< (OUT_W - 1));

  always_comb begin
    q_next = shifted[OUT_W-1:0];
    clip   = 1'b0;
    if (shifted > MAXV) begin
      q_next = MAXV[OUT_W-1:0];
      clip   = 1'b1;
    end else if (shifted < MINV) begin
      q_next = MINV[OUT_W-1:0];
      clip   = 1'b1;
    end
  end
`else
  always_comb begin
    q_next = shifted[OUT_W-1:0];
    clip   = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= '0;
    end else if (in_valid) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_sat   <= 1'b0;
    end else begin
      q_valid <= keep;
      if (keep) begin
        q_data <= q_next;
        q_sat  <= clip;
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = q_valid && (!fifo_full || pop);

  // A refused write discards the staged sample; its clip status is discarded with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= push && q_sat;
      if (q_valid && !push && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (q_data),
    .pop     (pop),
    .head    (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: decimation, rounding, saturation/wrap, FIFO full and reset.
module tb_fir_decimator;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // a: DECIM=4 FRAC_SHIFT=4; b: DECIM=1 FRAC_SHIFT=4; c: DECIM=1 FRAC_SHIFT=0
  logic        rst_a, v_a, rdy_a, ov_a, sat_a;
  logic        rst_b, v_b, rdy_b, ov_b, sat_b;
  logic        rst_c, v_c, rdy_c, ov_c, sat_c;
  logic [31:0] x_a, x_b, x_c;
  logic [15:0] od_a, od_b, od_c;
  logic [15:0] drop_a, drop_b, drop_c;

  exp_t sb_a[$], sb_b[$], sb_c[$];
  exp_t ea, eb, ec;
  int   pops_a = 0;
  int   first_a = -1;
  int   drive_a = 0;

  fir_decimator #(.DATA_W(32), .OUT_W(16), .FRAC_SHIFT(4), .DECIM(4), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset_n(rst_a), .x_in(x_a), .in_valid(v_a), .out_data(od_a),
    .out_valid(ov_a), .out_ready(rdy_a), .sat_flag(sat_a), .drop_cnt(drop_a));

  fir_decimator #(.DATA_W(32), .OUT_W(16), .FRAC_SHIFT(4), .DECIM(1), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .reset_n(rst_b), .x_in(x_b), .in_valid(v_b), .out_data(od_b),
    .out_valid(ov_b), .out_ready(rdy_b), .sat_flag(sat_b), .drop_cnt(drop_b));

  fir_decimator #(.DATA_W(32), .OUT_W(16), .FRAC_SHIFT(0), .DECIM(1), .FIFO_DEPTH(8)) dut_c (
    .clk(clk), .reset_n(rst_c), .x_in(x_c), .in_valid(v_c), .out_data(od_c),
    .out_valid(ov_c), .out_ready(rdy_c), .sat_flag(sat_c), .drop_cnt(drop_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_a && ov_a && rdy_a) begin
      if (sb_a.size() == 0) check("a_spurious", 32'(ov_a), 32'd0);
      else begin
        ea = sb_a.pop_front();
        check("a_data", 32'(od_a), 32'(ea.d));
        check("a_sat", 32'(sat_a), 32'(ea.s));
        pops_a++;
        if (first_a < 0) first_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b && ov_b && rdy_b) begin
      if (sb_b.size() == 0) check("b_spurious", 32'(ov_b), 32'd0);
      else begin
        eb = sb_b.pop_front();
        check("b_data", 32'(od_b), 32'(eb.d));
        check("b_sat", 32'(sat_b), 32'(eb.s));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_c && ov_c && rdy_c) begin
      if (sb_c.size() == 0) check("c_spurious", 32'(ov_c), 32'd0);
      else begin
        ec = sb_c.pop_front();
        check("c_data", 32'(od_c), 32'(ec.d));
      end
    end
  end

  int rx[5] = '{100, 200, -200, 8, 7};
  int ry[5] = '{6, 13, -12, 1, 0};

  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    v_a = 0; v_b = 0; v_c = 0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0;
    x_a = '0; x_b = '0; x_c = '0;
    repeat (3) tick();
    check("rst_valid", 32'(ov_a), 32'd0);
    check("rst_data", 32'(od_a), 32'd0);
    check("rst_drop", 32'(drop_c), 32'd0);
    check("rst_sat", 32'(sat_b), 32'd0);
    rst_a = 1; rst_b = 1; rst_c = 1;
    tick();

    // decimation by 4
    rdy_a = 1;
    for (int i = 1; i <= 8; i++) begin
      x_a = 32'(16 * i);
      v_a = 1;
      if (i == 1) begin drive_a = cyc; sb_a.push_back('{16'd1, 1'b0}); end
      if (i == 5) sb_a.push_back('{16'd5, 1'b0});
      tick();
    end
    v_a = 0;
    repeat (6) tick();
    check("a_count", 32'(pops_a), 32'd2);
    check("a_latency", 32'(first_a - drive_a), 32'd2);

    // rounding and saturation/wrap, one sample per clock
    rdy_b = 1;
    for (int i = 0; i < 5; i++) begin
      x_b = 32'(rx[i]);
      v_b = 1;
      sb_b.push_back('{16'(ry[i]), 1'b0});
      tick();
    end
    x_b = 32'(1000000);
`ifdef FIR_DECIM_SAT_EN
    sb_b.push_back('{16'h7FFF, 1'b1});
`else
    sb_b.push_back('{16'(-3036), 1'b0});
`endif
    tick();
    x_b = 32'(-1000000);
`ifdef FIR_DECIM_SAT_EN
    sb_b.push_back('{16'h8000, 1'b1});
`else
    sb_b.push_back('{16'(3036), 1'b0});
`endif
    tick();
    v_b = 0;
    repeat (5) tick();
    check("b_left", 32'(sb_b.size()), 32'd0);
    check("b_drop", 32'(drop_b), 32'd0);

    // fill past capacity with the consumer stalled
    for (int i = 1; i <= 10; i++) begin
      x_c = 32'(i);
      v_c = 1;
      if (i <= 8) sb_c.push_back('{16'(i), 1'b0});
      tick();
    end
    v_c = 0;
    repeat (3) tick();
    check("c_drop_full", 32'(drop_c), 32'd2);
    check("c_valid_full", 32'(ov_c), 32'd1);
    check("c_head_stall", 32'(od_c), 32'd1);

    // push and pop on the same edge while full
    x_c = 32'd11; v_c = 1;
    sb_c.push_back('{16'd11, 1'b0});
    tick();
    v_c = 0; rdy_c = 1;
    tick();
    rdy_c = 0;
    repeat (2) tick();
    check("c_drop_pushpop", 32'(drop_c), 32'd2);
    x_c = 32'd12; v_c = 1;
    tick();
    v_c = 0;
    repeat (3) tick();
    check("c_still_full", 32'(drop_c), 32'd3);

    rdy_c = 1;
    repeat (12) tick();
    check("c_drained", 32'(ov_c), 32'd0);
    check("c_left", 32'(sb_c.size()), 32'd0);

    // overflow again, then asynchronous reset clears everything
    rdy_c = 0;
    for (int i = 0; i < 20; i++) begin
      x_c = 32'(100 + i);
      v_c = 1;
      tick();
    end
    v_c = 0;
    repeat (3) tick();
    check("c_drop_again", 32'(drop_c), 32'd15);
    #2 rst_c = 0;
    #1;
    check("c_rst_valid", 32'(ov_c), 32'd0);
    check("c_rst_drop", 32'(drop_c), 32'd0);
    tick();
    rst_c = 1;

    // reset mid-stream with 3 samples buffered and ph=2
    rdy_a = 0;
    for (int i = 1; i <= 10; i++) begin
      x_a = 32'(16 * i);
      v_a = 1;
      tick();
    end
    v_a = 0;
    repeat (3) tick();
    check("a_buffered", 32'(ov_a), 32'd1);
    check("a_head", 32'(od_a), 32'd1);
    #2 rst_a = 0;
    #1;
    check("a_rst_valid", 32'(ov_a), 32'd0);
    check("a_rst_data", 32'(od_a), 32'd0);
    check("a_rst_drop", 32'(drop_a), 32'd0);
    tick();
    rst_a = 1;
    tick();
    rdy_a = 1;
    x_a = 32'd48; v_a = 1;
    sb_a.push_back('{16'd3, 1'b0});
    tick();
    v_a = 0;
    repeat (5) tick();
    check("a_left", 32'(sb_a.size()), 32'd0);
    check("a_total", 32'(pops_a), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
